aer_event_queue: RTL and testbench
==================================

Name: aer_event_queue

Overview:
- Downstream of the pixel spike encoder: consumes its per-pixel spike lines, timestamps every spike, and serializes collisions through a round-robin arbiter into a FIFO.
- Presents one AER event (address + timestamp) per cycle on a valid/ready interface to the synapse/neuron layer.
- Replaces the encoder's lossy first-spike-wins aer_addr bus; no simultaneous spike is lost unless buffering is exhausted.

Parameters:
NUM_INPUTS, 4, number of spike input lines (address width = clog2(NUM_INPUTS), 2 at default)
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
TS_WIDTH, 8, timestamp counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  capture enable; low clears timestamp and pending state
spike_in  input  NUM_INPUTS  one-cycle spike pulses; bit i = encoder spike_out_i
ev_valid  output  1  FIFO head holds an event
ev_ready  input  1  consumer accepts head event
ev_addr  output  clog2(NUM_INPUTS)  address of head event
ev_ts  output  TS_WIDTH  timestamp of head event
fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy
drop_count  output  16  saturating count of refused spikes
busy  output  1  any pending bit set or FIFO non-empty

Behaviour:
- Reset (async, rst_n low): all outputs 0; ts_counter, pending, pend_ts, FIFO pointers/count, drop_count = 0; last_grant = NUM_INPUTS-1.
- ts_counter: +1 every cycle while enable, wraps modulo 2^TS_WIDTH; forced to 0 while enable low.
- Capture: spike_in[i] sampled at edge with enable high sets pending[i]; pend_ts[i] = ts_counter value at that edge (pre-increment).
- Capture conflict: if pending[i] already set and not granted this edge, spike is refused; drop_count +1 (saturate at 0xFFFF); pend_ts[i] keeps the older value. Multiple refusals in one cycle add their total.
- Same-edge grant and new spike on input i: old event written to FIFO; pending[i] stays set with the new timestamp; no drop.
- Arbiter: each edge with pending != 0 and FIFO not full, grants exactly one input: first set bit scanning from last_grant+1 upward, wrapping. Pushes {i, pend_ts[i]}, clears pending[i] (unless re-set), last_grant = i.
- Full FIFO blocks grant even if a pop occurs the same edge.
- FIFO: show-ahead. ev_valid = count != 0; ev_addr/ev_ts = head entry, held stable while ev_valid & !ev_ready; pop on ev_valid & ev_ready. Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: spike sampled at edge k -> earliest FIFO write at edge k+1 -> ev_valid high after edge k+1 (2 cycles).
- enable low: pending and pend_ts cleared synchronously; spike_in ignored (not counted as drops). FIFO contents retained and continue draining. drop_count cleared only by reset.
- busy = |pending | (count != 0).
- Reset asserted mid-operation: immediate return to reset state; in-flight events discarded.

Test Plan:
1. Reset, enable=1, ev_ready=1; pulse spike_in=4'b0001 at edge where ts_counter=3 -> after 2 edges, ev_valid=1 for one cycle with ev_addr=0, ev_ts=3; drop_count=0.
2. spike_in=4'b1111 for one cycle at ts=5, ev_ready=1 -> events on addr 0,1,2,3 on four consecutive cycles, all ev_ts=5; busy falls after the last pop.
3. ev_ready=0, spike_in[1] high for 20 cycles starting at ts=k -> fifo_count reaches 8 (ts k..k+7), drop_count=11, pending[1] held with ts k+8. Then ev_ready=1 -> 9 events drain in order, ts k..k+8.
4. spike_in[0] and spike_in[3] held high, ev_ready=1 -> grants alternate 0,3,0,3...; drop_count increments by 1 per cycle after the first grant.
5. With 3 events queued and 2 pending, drop enable -> pending cleared, ts_counter=0. Exactly the 3 queued events are still delivered; no further events appear.
6. Assert rst_n low mid-burst with FIFO half full -> all outputs 0 immediately (asynchronous). After release, first new spike is granted in order starting from address 0.

Source files
------------

// File: rtl/aer_event_queue.sv
// aer_event_queue
//   Timestamps every spike from the pixel spike encoder, serializes
//   simultaneous spikes through a round-robin arbiter and buffers them in a
//   show-ahead FIFO. One AER event {address, timestamp} is offered per cycle
//   on a valid/ready interface to the synapse/neuron layer.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       capture enable; low clears timestamp and pending state
//   spike_in     one-cycle spike pulses, bit i = encoder spike_out_i
//   ev_valid     FIFO head holds an event
//   ev_ready     consumer accepts the head event
//   ev_addr      address of the head event (0 while empty)
//   ev_ts        timestamp of the head event (0 while empty)
//   fifo_count   current FIFO occupancy
//   drop_count   saturating count of refused spikes (cleared only by reset)
//   busy         any spike pending or FIFO non-empty
module aer_event_queue #(
  parameter int NUM_INPUTS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 8,
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] spike_in,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [AW-1:0]         ev_addr,
  output logic [TS_WIDTH-1:0]   ev_ts,
  output logic [CW-1:0]         fifo_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [NUM_INPUTS-1:0] pending_q, pending_d;
  logic [TS_WIDTH-1:0]   pend_ts_q [NUM_INPUTS];
  logic [TS_WIDTH-1:0]   pend_ts_d [NUM_INPUTS];
  logic [AW-1:0]         last_grant_q, last_grant_d;
  logic [15:0]           drop_count_q, drop_count_d;

  logic [AW-1:0]         mem_addr_q [FIFO_DEPTH];
  logic [AW-1:0]         mem_addr_d [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts_q   [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts_d   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  grant_hit;
  logic [AW-1:0]         grant_idx;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [16:0]           refusals;
  logic [16:0]           drop_sum;

  // Round-robin search: offsets are scanned from the farthest to the nearest
  // so the last hit is the first pending bit after last_grant.
  always_comb begin
    int scan_idx;
    scan_idx  = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int off = NUM_INPUTS; off >= 1; off--) begin
      scan_idx = int'(last_grant_q) + off;
      if (scan_idx >= NUM_INPUTS) scan_idx = scan_idx - NUM_INPUTS;
      if (pending_q[AW'(scan_idx)]) begin
        grant_hit = 1'b1;
        grant_idx = AW'(scan_idx);
      end
    end
  end

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  // A full FIFO refuses the push even when the head pops on the same edge.
  // Grants are also suppressed while disabled so that no pending spike
  // leaks into the FIFO on the edge that clears it.
  assign push = enable & grant_hit & ~fifo_full;
  assign pop  = (count_q != '0) & ev_ready;

  always_comb begin
    logic granted;
    granted   = 1'b0;
    ts_d      = enable ? ts_q + TS_WIDTH'(1) : '0;
    pending_d = pending_q;
    pend_ts_d = pend_ts_q;
    refusals  = '0;
    if (!enable) begin
      pending_d = '0;
      for (int i = 0; i < NUM_INPUTS; i++) pend_ts_d[i] = '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        granted = push && (grant_idx == AW'(i));
        if (spike_in[i]) begin
          // A new spike on a slot whose old event is leaving this edge
          // simply takes the slot over; otherwise the older stamp wins.
          if (pending_q[i] && !granted) begin
            refusals = refusals + 17'd1;
          end else begin
            pending_d[i] = 1'b1;
            pend_ts_d[i] = ts_q;
          end
        end else if (granted) begin
          pending_d[i] = 1'b0;
        end
      end
    end
    drop_sum     = {1'b0, drop_count_q} + refusals;
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    last_grant_d = push ? grant_idx : last_grant_q;
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_ts_d   = mem_ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = grant_idx;
      mem_ts_d[wr_ptr_q]   = pend_ts_q[grant_idx];
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      pending_q    <= '0;
      last_grant_q <= AW'(NUM_INPUTS - 1);
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) pend_ts_q[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_addr_q[j] <= '0;
        mem_ts_q[j]   <= '0;
      end
    end else begin
      ts_q         <= ts_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_ts_q    <= pend_ts_d;
      mem_addr_q   <= mem_addr_d;
      mem_ts_q     <= mem_ts_d;
    end
  end

  // Head fields read zero while empty so stale entries never show.
  assign ev_valid   = (count_q != '0);
  assign ev_addr    = ev_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign ev_ts      = ev_valid ? mem_ts_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign drop_count = drop_count_q;
  assign busy       = (|pending_q) | (count_q != '0);

endmodule

// File: tb/tb_aer_event_queue.sv
module tb_aer_event_queue;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  spike_in;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_addr;
  logic [7:0]  ev_ts;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  aer_event_queue #(.NUM_INPUTS(4), .FIFO_DEPTH(8), .TS_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .spike_in   (spike_in),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_addr    (ev_addr),
    .ev_ts      (ev_ts),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  sp;
    logic        rdy;
    logic        v;
    logic [1:0]  a;
    logic [7:0]  t;
    logic [3:0]  c;
    logic [15:0] d;
    logic        b;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic e, logic [3:0] s, logic rd,
                              logic v, logic [1:0] a, logic [7:0] t,
                              logic [3:0] c, logic [15:0] d, logic b);
    vec_t x;
    x.rst_n = r; x.en = e; x.sp = s; x.rdy = rd;
    x.v = v; x.a = a; x.t = t; x.c = c; x.d = d; x.b = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {ev_valid, ev_addr, ev_ts, fifo_count, drop_count, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("reset_outputs", outs(), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; spike_in = '0; ev_ready = 1'b0;

    // rows: rst en spike rdy | valid addr ts count drop busy
    vecs[0]  = mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // single spike at ts=3, event visible two edges later
    vecs[1]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(1, 1, 4'b0000, 1, 1, 0, 3, 1, 0, 1);
    vecs[6]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    // reset, then all four spike at ts=5 and drain in address order
    vecs[7]  = mk(0, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, 4'b1111, 1, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 1, 4'b0000, 1, 1, 0, 5, 1, 0, 1);
    vecs[15] = mk(1, 1, 4'b0000, 1, 1, 1, 5, 1, 0, 1);
    vecs[16] = mk(1, 1, 4'b0000, 1, 1, 2, 5, 1, 0, 1);
    vecs[17] = mk(1, 1, 4'b0000, 1, 1, 3, 5, 1, 0, 1);
    vecs[18] = mk(1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      rst_n    = vecs[i].rst_n;
      enable   = vecs[i].en;
      spike_in = vecs[i].sp;
      ev_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].v, vecs[i].a, vecs[i].t, vecs[i].c, vecs[i].d, vecs[i].b});
    end

    // Overflow: input 1 held for 20 cycles with consumer stalled.
    do_reset();
    enable = 1'b1; ev_ready = 1'b0; spike_in = 4'b0010;
    for (int n = 0; n < 20; n++) tick();
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd11);
    chk("ovf_busy", 32'(busy), 32'd1);
    spike_in = '0; ev_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      chk($sformatf("ovf_head%0d", i), {23'd0, ev_valid, ev_addr, ev_ts},
          {23'd0, 1'b1, 2'd1, 8'(i)});
      tick();
      if (i == 0) chk("full_blocks_grant", 32'(fifo_count), 32'd7);
    end
    chk("ovf_empty", {ev_valid, busy, fifo_count}, 6'b000000);
    chk("ovf_drop_kept", 32'(drop_count), 32'd11);

    // Two inputs held: grants alternate, one refusal per cycle after first grant.
    do_reset();
    enable = 1'b1; ev_ready = 1'b1; spike_in = 4'b1001;
    tick();
    chk("alt_first", {ev_valid, drop_count}, 17'd0);
    for (int n = 2; n <= 9; n++) begin
      tick();
      chk($sformatf("alt_addr%0d", n), 32'(ev_addr), (n % 2 == 0) ? 32'd0 : 32'd3);
      chk($sformatf("alt_drop%0d", n), 32'(drop_count), 32'(n - 1));
      chk($sformatf("alt_cnt%0d", n), 32'(fifo_count), 32'd1);
      if (n >= 3) chk($sformatf("alt_ts%0d", n), 32'(ev_ts), 32'(n - 3));
    end

    // Disable with 3 queued and 2 pending.
    do_reset();
    enable = 1'b1; ev_ready = 1'b0; spike_in = 4'b1111;
    tick();
    spike_in = 4'b0000; tick(); tick();
    spike_in = 4'b0010; tick();
    chk("dis_before", {fifo_count, busy}, {4'd3, 1'b1});
    enable = 1'b0; spike_in = 4'b0000; tick();
    chk("dis_after", {fifo_count, busy}, {4'd3, 1'b1});
    ev_ready = 1'b1; spike_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dis_head%0d", i), {ev_valid, ev_addr, ev_ts}, {1'b1, 2'(i), 8'd0});
      tick();
    end
    chk("dis_drained", {ev_valid, busy, fifo_count, drop_count}, 22'd0);
    for (int n = 0; n < 3; n++) tick();
    chk("dis_quiet", {ev_valid, busy, drop_count}, 18'd0);
    enable = 1'b1; spike_in = 4'b0001; tick();
    spike_in = 4'b0000; tick();
    chk("ts_restart", {ev_valid, ev_addr, ev_ts}, {1'b1, 2'd0, 8'd0});
    tick();

    // Asynchronous reset mid-burst with FIFO half full.
    do_reset();
    enable = 1'b1; ev_ready = 1'b0; spike_in = 4'b1111;
    tick();
    spike_in = 4'b0000;
    for (int n = 0; n < 4; n++) tick();
    chk("half_full", 32'(fifo_count), 32'd4);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 32'h0);
    rst_n = 1'b1; spike_in = 4'b1111; ev_ready = 1'b1;
    tick();
    spike_in = 4'b0000; tick();
    chk("post_rst_first", {ev_valid, ev_addr, ev_ts, fifo_count}, {1'b1, 2'd0, 8'd0, 4'd1});
    tick();
    chk("post_rst_second", {ev_valid, ev_addr, ev_ts}, {1'b1, 2'd1, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
